// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller and its
// neighbours in the RV32IM pipeline.
package interrupt_controller_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAVE   = 2'd1;
  localparam logic [1:0] ST_IN_ISR = 2'd2;

  localparam logic [31:0] DEF_ISR_BASE   = 32'h0000_0100;
  localparam int          DEF_ISR_STRIDE = 16;

  // Return-PC register, also used by reg_file
  localparam logic [4:0] RET_REG_IDX = 5'd30;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser, edge flop and registered
// rising-edge pulse for one interrupt line.
module irq_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_irq,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_irq;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/interrupt_controller.sv
// Latches external interrupt edges, picks the lowest-index
// enabled one and steers the pipeline into its ISR.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] ISR_BASE   = DEF_ISR_BASE,
  parameter int          ISR_STRIDE = DEF_ISR_STRIDE
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] IRQ_ENABLE,
  input  logic [31:0]        PC_NEXT,
  input  logic               PIPE_SAFE,
  input  logic               ISR_RETURN,
  output logic               INTERUPT_PC_REG_EN,
  output logic [31:0]        PC_NEXT_REGFILE,
  output logic               ISR_PC_SEL,
  output logic [31:0]        ISR_PC,
  output logic               PIPE_FLUSH,
  output logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic               IN_ISR,
  output logic [2:0]         ACTIVE_ID
);

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_onehot;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] r_pend;
  logic [2:0]         w_id;
  logic               w_any;
  logic               w_save;
  logic [1:0]         r_state;
  logic [2:0]         r_id;
  logic [31:0]        r_pc;
  logic [31:0]        r_vec;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    irq_sync_edge u_sync (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_irq   (IRQ[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  assign w_elig = r_pend & IRQ_ENABLE;

  always_comb begin
    w_id  = 3'd0;
    w_any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_id  = 3'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_save   = (r_state == ST_SAVE);
  assign w_onehot = NUM_IRQ'(1) << r_id;
  assign w_clr    = w_save ? w_onehot : '0;

  // A new edge in the clearing cycle must survive
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_rise;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_id    <= 3'd0;
      r_pc    <= 32'd0;
      r_vec   <= 32'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any && PIPE_SAFE) begin
            r_state <= ST_SAVE;
            r_id    <= w_id;
            r_pc    <= PC_NEXT;
            r_vec   <= ISR_BASE
                     + 32'(w_id) * 32'(ISR_STRIDE);
          end
        end
        ST_SAVE: r_state <= ST_IN_ISR;
        ST_IN_ISR: begin
          if (ISR_RETURN) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign INTERUPT_PC_REG_EN = w_save;
  assign ISR_PC_SEL         = w_save;
  assign PIPE_FLUSH         = w_save;
  assign IRQ_ACK            = w_clr;
  assign PC_NEXT_REGFILE    = r_pc;
  assign ISR_PC             = r_vec;
  assign IN_ISR             = (r_state == ST_IN_ISR);
  assign ACTIVE_ID          = r_id;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected SAVE
// records are queued at stimulus time and checked on SAVE.
module tb_interrupt_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  IRQ;
  logic [3:0]  IRQ_ENABLE;
  logic [31:0] PC_NEXT;
  logic        PIPE_SAFE;
  logic        ISR_RETURN;
  logic        INTERUPT_PC_REG_EN;
  logic [31:0] PC_NEXT_REGFILE;
  logic        ISR_PC_SEL;
  logic [31:0] ISR_PC;
  logic        PIPE_FLUSH;
  logic [3:0]  IRQ_ACK;
  logic        IN_ISR;
  logic [2:0]  ACTIVE_ID;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vec;
    logic [3:0]  ack;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc;
  bit   seen;

  interrupt_controller dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .IRQ                (IRQ),
    .IRQ_ENABLE         (IRQ_ENABLE),
    .PC_NEXT            (PC_NEXT),
    .PIPE_SAFE          (PIPE_SAFE),
    .ISR_RETURN         (ISR_RETURN),
    .INTERUPT_PC_REG_EN (INTERUPT_PC_REG_EN),
    .PC_NEXT_REGFILE    (PC_NEXT_REGFILE),
    .ISR_PC_SEL         (ISR_PC_SEL),
    .ISR_PC             (ISR_PC),
    .PIPE_FLUSH         (PIPE_FLUSH),
    .IRQ_ACK            (IRQ_ACK),
    .IN_ISR             (IN_ISR),
    .ACTIVE_ID          (ACTIVE_ID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic wait_save(input int bound,
                           output int n,
                           output bit hit);
    hit = 1'b0;
    n   = 0;
    while (!hit && n < bound) begin
      @(negedge CLK);
      n++;
      if (INTERUPT_PC_REG_EN === 1'b1) hit = 1'b1;
    end
  endtask

  task automatic do_return();
    ISR_RETURN = 1'b1;
    @(negedge CLK);
    ISR_RETURN = 1'b0;
  endtask

  task automatic settle();
    IRQ = 4'b0000;
    repeat (5) @(negedge CLK);
    q.delete();
  endtask

  task automatic test_reset();
    RESET      = 1'b0;
    IRQ        = 4'b0000;
    IRQ_ENABLE = 4'h0;
    PC_NEXT    = 32'h0;
    PIPE_SAFE  = 1'b0;
    ISR_RETURN = 1'b0;
    #12;
    nvec++;
    if ({INTERUPT_PC_REG_EN, PC_NEXT_REGFILE, ISR_PC_SEL,
         ISR_PC, PIPE_FLUSH, IRQ_ACK, IN_ISR,
         ACTIVE_ID} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got en=%b pc=%h sel=%b vec=%h fl=%b ack=%b in=%b id=%0d want all 0",
               INTERUPT_PC_REG_EN, PC_NEXT_REGFILE, ISR_PC_SEL,
               ISR_PC, PIPE_FLUSH, IRQ_ACK, IN_ISR, ACTIVE_ID);
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single();
    IRQ_ENABLE = 4'hF;
    PIPE_SAFE  = 1'b1;
    PC_NEXT    = 32'h0000_0040;
    IRQ        = 4'b0100;
    q.push_back('{pc: 32'h40, vec: 32'h120, ack: 4'b0100});
    wait_save(20, cyc, seen);
    nvec++;
    if (!seen || cyc != 5) begin
      nerr++;
      $display("FAIL single_latency: got %0d cycles (seen=%b) want 5",
               cyc, seen);
    end
    if (seen) begin
      e = q.pop_front();
      nvec++;
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK, PIPE_FLUSH, ISR_PC_SEL}
          !== {e.pc, e.vec, e.ack, 2'b11}) begin
        nerr++;
        $display("FAIL single_save: got pc=%h vec=%h ack=%b fl=%b sel=%b want pc=%h vec=%h ack=%b fl=1 sel=1",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK, PIPE_FLUSH,
                 ISR_PC_SEL, e.pc, e.vec, e.ack);
      end
    end
    @(negedge CLK);
    nvec++;
    if ({IN_ISR, ACTIVE_ID, INTERUPT_PC_REG_EN, IRQ_ACK}
        !== {1'b1, 3'd2, 1'b0, 4'b0000}) begin
      nerr++;
      $display("FAIL single_in_isr: got in=%b id=%0d en=%b ack=%b want in=1 id=2 en=0 ack=0000",
               IN_ISR, ACTIVE_ID, INTERUPT_PC_REG_EN, IRQ_ACK);
    end
    do_return();
    nvec++;
    if ({IN_ISR, ISR_PC, PC_NEXT_REGFILE}
        !== {1'b0, 32'h120, 32'h40}) begin
      nerr++;
      $display("FAIL single_after_ret: got in=%b vec=%h pc=%h want in=0 vec=00000120 pc=00000040",
               IN_ISR, ISR_PC, PC_NEXT_REGFILE);
    end
    settle();
  endtask

  task automatic test_priority();
    PC_NEXT = 32'h80;
    IRQ     = 4'b1010;
    q.push_back('{pc: 32'h80, vec: 32'h110, ack: 4'b0010});
    q.push_back('{pc: 32'h84, vec: 32'h130, ack: 4'b1000});
    wait_save(20, cyc, seen);
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL prio_first_timeout: got no SAVE want SAVE");
    end else begin
      e = q.pop_front();
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL prio_first: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    PC_NEXT = 32'h84;
    wait_save(8, cyc, seen);
    nvec++;
    if (seen || IN_ISR !== 1'b1 || ACTIVE_ID !== 3'd1) begin
      nerr++;
      $display("FAIL prio_no_nest: got save=%b in=%b id=%0d want save=0 in=1 id=1",
               seen, IN_ISR, ACTIVE_ID);
    end
    do_return();
    wait_save(5, cyc, seen);
    nvec++;
    if (!seen || cyc != 1) begin
      nerr++;
      $display("FAIL prio_second_timing: got %0d cycles (seen=%b) want 1",
               cyc, seen);
    end
    if (seen) begin
      e = q.pop_front();
      nvec++;
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL prio_second: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    @(negedge CLK);
    do_return();
    settle();
  endtask

  task automatic test_unsafe();
    PIPE_SAFE = 1'b0;
    PC_NEXT   = 32'h200;
    IRQ       = 4'b0001;
    wait_save(14, cyc, seen);
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL unsafe_blocked: got SAVE while unsafe want none");
    end
    PIPE_SAFE = 1'b1;
    PC_NEXT   = 32'h204;
    q.push_back('{pc: 32'h204, vec: 32'h100, ack: 4'b0001});
    wait_save(5, cyc, seen);
    nvec++;
    if (!seen || cyc != 1) begin
      nerr++;
      $display("FAIL unsafe_release: got %0d cycles (seen=%b) want 1",
               cyc, seen);
    end
    if (seen) begin
      e = q.pop_front();
      nvec++;
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL unsafe_save: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    PC_NEXT = 32'h300;
    @(negedge CLK);
    nvec++;
    if (PC_NEXT_REGFILE !== 32'h204) begin
      nerr++;
      $display("FAIL unsafe_pc_hold: got %h want 00000204",
               PC_NEXT_REGFILE);
    end
    do_return();
    settle();
  endtask

  task automatic test_mask();
    IRQ_ENABLE = 4'b1101;
    PC_NEXT    = 32'h500;
    IRQ        = 4'b0010;
    wait_save(15, cyc, seen);
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL mask_blocked: got SAVE with line masked want none");
    end
    IRQ_ENABLE = 4'hF;
    q.push_back('{pc: 32'h500, vec: 32'h110, ack: 4'b0010});
    wait_save(5, cyc, seen);
    nvec++;
    if (!seen || cyc != 1) begin
      nerr++;
      $display("FAIL mask_enable: got %0d cycles (seen=%b) want 1",
               cyc, seen);
    end
    if (seen) begin
      e = q.pop_front();
      nvec++;
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL mask_save: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    @(negedge CLK);
    do_return();
    wait_save(15, cyc, seen);
    nvec++;
    if (seen) begin
      nerr++;
      $display("FAIL level_hold: got repeat SAVE on held level want none");
    end
    settle();
  endtask

  task automatic test_collision();
    PC_NEXT = 32'h600;
    q.push_back('{pc: 32'h600, vec: 32'h100, ack: 4'b0001});
    q.push_back('{pc: 32'h600, vec: 32'h100, ack: 4'b0001});
    IRQ = 4'b0001;
    @(negedge CLK);
    IRQ = 4'b0000;
    @(negedge CLK);
    IRQ = 4'b0001;
    wait_save(10, cyc, seen);
    nvec++;
    if (!seen || cyc != 3) begin
      nerr++;
      $display("FAIL coll_first: got %0d cycles (seen=%b) want 3",
               cyc, seen);
    end
    if (seen) begin
      e = q.pop_front();
      nvec++;
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL coll_first_save: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    @(negedge CLK);
    do_return();
    wait_save(5, cyc, seen);
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL coll_lost: got no second SAVE want SAVE for line 0");
    end else begin
      e = q.pop_front();
      if ({PC_NEXT_REGFILE, ISR_PC, IRQ_ACK}
          !== {e.pc, e.vec, e.ack}) begin
        nerr++;
        $display("FAIL coll_second_save: got pc=%h vec=%h ack=%b want pc=%h vec=%h ack=%b",
                 PC_NEXT_REGFILE, ISR_PC, IRQ_ACK,
                 e.pc, e.vec, e.ack);
      end
    end
    @(negedge CLK);
    do_return();
    settle();
  endtask

  task automatic test_reset_mid_isr();
    PC_NEXT = 32'h700;
    IRQ     = 4'b0001;
    wait_save(20, cyc, seen);
    IRQ = 4'b0111;
    repeat (6) @(negedge CLK);
    nvec++;
    if (!seen || IN_ISR !== 1'b1) begin
      nerr++;
      $display("FAIL rst_setup: got save=%b in=%b want save=1 in=1",
               seen, IN_ISR);
    end
    #2;
    RESET = 1'b0;
    #1;
    nvec++;
    if ({INTERUPT_PC_REG_EN, PC_NEXT_REGFILE, ISR_PC_SEL,
         ISR_PC, PIPE_FLUSH, IRQ_ACK, IN_ISR,
         ACTIVE_ID} !== '0) begin
      nerr++;
      $display("FAIL rst_mid_isr: got pc=%h vec=%h in=%b id=%0d ack=%b want all 0",
               PC_NEXT_REGFILE, ISR_PC, IN_ISR, ACTIVE_ID, IRQ_ACK);
    end
    IRQ = 4'b0000;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    wait_save(20, cyc, seen);
    nvec++;
    if (seen || IN_ISR !== 1'b0) begin
      nerr++;
      $display("FAIL rst_pending_drop: got save=%b in=%b want save=0 in=0",
               seen, IN_ISR);
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_unsafe();
    test_mask();
    test_collision();
    test_reset_mid_isr();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
